// File: rtl/seq_gen_11011.sv
// seq_gen_11011: Moore serial transmitter of a repeated bit pattern with optional zero gaps and valid/ready handshake
module seq_gen_11011 #(
  parameter int PAT_W = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b11011,
  parameter int GAP_BITS = 0,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REP_W-1:0] reps,
  input  logic             ready,
  output logic             signal,
  output logic             sig_valid,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] reps_left
);
  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t r_state;
  logic [PAT_W-1:0] r_shift;
  logic [BW-1:0] r_bit_cnt;
  logic [3:0] r_gap_cnt;
  logic [REP_W-1:0] r_reps_left;
  // burst sequencing: pattern shifting, repetition countdown and gap insertion, advancing only on accepted bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_reps_left <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          if (reps != '0) begin
            r_shift <= PATTERN;
            r_bit_cnt <= '0;
            r_reps_left <= reps;
            r_state <= SEND;
          end else r_state <= DONE;
        end
        SEND: if (ready) begin
          if (r_bit_cnt != LAST) begin
            r_shift <= r_shift << 1;
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end else begin
            r_reps_left <= r_reps_left - REP_W'(1);
            if (r_reps_left == REP_W'(1)) r_state <= DONE;
            else if (GAP_BITS > 0) begin
              r_gap_cnt <= '0;
              r_state <= GAP;
            end else begin
              r_shift <= PATTERN;
              r_bit_cnt <= '0;
            end
          end
        end
        GAP: if (ready) begin
          r_gap_cnt <= r_gap_cnt + 4'd1;
          if (r_gap_cnt == GAP_LAST) begin
            r_shift <= PATTERN;
            r_bit_cnt <= '0;
            r_state <= SEND;
          end
        end
        DONE: begin
          r_reps_left <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign signal = (r_state == SEND) & r_shift[PAT_W-1];
  assign sig_valid = (r_state == SEND) | (r_state == GAP);
  assign busy = sig_valid;
  assign done = r_state == DONE;
  assign reps_left = r_reps_left;
endmodule

// File: doc/seq_gen_11011.md
Name: seq_gen_11011

Overview:
- Moore FSM serial pattern transmitter. It is the source-side counterpart of the 11011 non-overlapping Moore sequence detector.
- On a start request it emits the 5-bit pattern 11011, MSB first, for a programmable number of back-to-back repetitions.
- An optional run of 0 gap bits is inserted between repetitions.
- It feeds detector benches and serial links through a valid/ready bit handshake.

Parameters:
- PAT_W, 5, pattern length in bits (at least 2).
- PATTERN, 5'b11011, pattern sent MSB first.
- GAP_BITS, 0, number of 0 bits inserted between consecutive repetitions (0 to 15). No gap bits follow the last repetition.
- REP_W, 8, width of the repetition count.

Ports:
- clk  input  1  clock; all state changes on the posedge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to begin a burst; sampled only in IDLE.
- reps  input  REP_W  number of pattern repetitions; latched when start is accepted.
- ready  input  1  downstream accepts the current bit when sig_valid and ready are both high on a clock edge.
- signal  output  1  serial data bit.
- sig_valid  output  1  signal carries a bit to be accepted.
- busy  output  1  high in SEND and GAP.
- done  output  1  one-cycle pulse when a burst completes.
- reps_left  output  REP_W  repetitions not yet fully transmitted, including the current one.

Behaviour:
- Reset: rst=1 at a posedge sends the FSM to IDLE and clears the shift register, bit counter, gap counter and reps_left. All outputs read 0 after that edge. Reset overrides every other input and aborts any burst in progress without a done pulse.
- States: IDLE, SEND, GAP, DONE. All outputs are Moore outputs, decoded from registered state only; no output depends combinationally on inputs.
- IDLE: signal=0, sig_valid=0, busy=0.
  - start=1 and reps!=0: load shift register with PATTERN, bit_cnt=0, reps_left=reps, go to SEND.
  - start=1 and reps=0: go to DONE with no bits sent.
  - start=0: stay in IDLE.
- SEND: signal=shift register MSB, sig_valid=1, busy=1.
  - ready=0: hold everything (signal stable, no shift).
  - ready=1 and bit_cnt<PAT_W-1: shift left, bit_cnt+1.
  - ready=1 and bit_cnt=PAT_W-1 (last bit accepted): decrement reps_left.
    - reps_left was 1: go to DONE.
    - Else if GAP_BITS>0: go to GAP with gap_cnt=0.
    - Else: reload PATTERN, bit_cnt=0, stay in SEND. Consecutive repetitions are gap-free.
- GAP: signal=0, sig_valid=1, busy=1.
  - Each accepted bit increments gap_cnt.
  - The GAP_BITS-th accepted bit reloads PATTERN, sets bit_cnt=0 and goes to SEND.
  - ready=0 holds the state.
- DONE: done=1 for exactly one cycle, signal=0, sig_valid=0, busy=0, reps_left=0. Next state is IDLE unconditionally.
- start outside IDLE is ignored, including in DONE. A new burst needs start high in a later IDLE cycle.
- Latency:
  - start accepted at edge k puts the first bit on signal after edge k.
  - With ready held high, a burst of N repetitions is accepted in N*PAT_W + (N-1)*GAP_BITS cycles.
  - done rises on the edge after the last bit is accepted.
- reps changes while busy have no effect.
- reps=2^REP_W-1 must complete without wrap-around of reps_left.
- Output contract: with GAP_BITS=0 the accepted bit stream is the pattern repeated exactly N times. A non-overlapping 11011 Moore detector fed this stream at one bit per cycle must assert exactly N times.

Test Plan:
- Reset, then start=1 with reps=1, ready=1 -> signal 1,1,0,1,1 on 5 consecutive cycles with sig_valid=1; done pulses in the following cycle; busy is low the cycle after that.
- reps=3, GAP_BITS=0, ready=1 -> 15 accepted bits 110111101111011; reps_left steps 3,2,1; the downstream 11011 detector asserts 3 times; exactly one done pulse.
- ready driven by the pattern 1,0,0,1,1,0,1,1,1 during reps=1 -> signal holds stable whenever ready=0; the accepted sequence is still 11011; done follows the 5th accepted bit.
- start with reps=0 -> sig_valid never rises; done pulses 1 cycle after the start edge; then back to IDLE.
- GAP_BITS=2 build, reps=2 -> accepted stream 11011 00 11011 (12 bits); no trailing gap; done follows the 12th bit.
- rst=1 asserted at the 3rd bit of a reps=4 burst -> the next cycle shows all outputs 0 and no done pulse; a new start with reps=1 then produces a clean 11011.
